ise_smc_pipe: RTL
=================

ISE_SMC_PIPE -- requirements
Module: ise_smc_pipe

Interface
REQ-001 Parameter N_DEV, default 6: devices per frame; legal range 3..64.
REQ-002 Parameter IN_W, default 3: width of W, V_GS, V_DS.
REQ-003 Derived VAL_W = 3*IN_W (per-device value width); OUT_W = VAL_W+4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  one device beat present this cycle.
REQ-007 mode  in  2  frame mode; sampled on the first beat of a frame only.
REQ-008 W, V_GS, V_DS  in  IN_W each  device width, gate-source and drain-source voltage (unsigned).
REQ-009 out_valid  out  1  out_n valid, one-cycle pulse per frame.
REQ-010 out_n  out  OUT_W  frame result.

Function
REQ-011 Per beat, unsigned, VTH=1: vov = V_GS-1, or 0 when V_GS=0 (cutoff, I_D=G_M=0).
REQ-012 Triode when vov > V_DS: I_D = floor(W*(2*vov*V_DS - V_DS^2)/3); G_M = floor(2*W*V_DS/3).
REQ-013 Saturation otherwise: I_D = floor(W*vov^2/3); G_M = floor(2*W*vov/3).
REQ-014 All intermediates full width; no truncation of any per-device value (VAL_W bits).
REQ-015 mode[0]=1 selects I_D, 0 selects G_M, for every beat of the frame.
REQ-016 Each accepted beat is inserted into an N_DEV-entry descending-sorted buffer in the cycle it is sampled; equal values may sit in any order.
REQ-017 FSM states IDLE, COLLECT, DONE; reset state IDLE.
REQ-018 IDLE: in_valid=1 -> latch mode, insert beat, count=1, go COLLECT.
REQ-019 COLLECT: in_valid=1 inserts beat and increments count; in_valid=0 holds (gaps of any length allowed).
REQ-020 The beat bringing count to N_DEV moves FSM to DONE.
REQ-021 DONE lasts exactly one cycle: out_valid=1, out_n registered; then IDLE with buffer and count cleared.
REQ-022 Latency: out_valid high in the cycle immediately after the edge sampling beat N_DEV.
REQ-023 Let S0>=S1>=...>=S(N_DEV-1) be the sorted values.
REQ-024 mode=11: out_n = 3*S0+4*S1+5*S2.
REQ-025 mode=10: out_n = S0+S1+S2.
REQ-026 mode=01: out_n = 3*S(N-3)+4*S(N-2)+5*S(N-1).
REQ-027 mode=00: out_n = S(N-3)+S(N-2)+S(N-1).
REQ-028 out_n is zero whenever out_valid=0.
REQ-029 in_valid asserted during DONE is ignored (not counted, not stored).
REQ-030 mode changes after the first beat of a frame have no effect on that frame.

Reset
REQ-031 rst_n low: immediately out_valid=0, out_n=0, FSM=IDLE, count=0, buffer cleared, latched mode=00.
REQ-032 Reset mid-frame discards all partial beats; next beat after release starts a new frame.
REQ-033 No output pulse is produced for an aborted frame.

Verification
REQ-034 N_DEV=6, six beats W=7,V_GS=7,V_DS=7 (sat, I_D=84, G_M=28): mode=11 -> out_n=1008; mode=10 -> 84; mode=00 -> 84; out_valid one cycle after 6th beat.
REQ-035 Triode: six beats W=3,V_GS=5,V_DS=2 (I_D=12, G_M=4), mode=01 -> out_n=144; mode=00 -> 12.
REQ-036 Mixed: five beats W=0 plus one W=7,V_GS=7,V_DS=7: mode=11 -> 252; mode=01 -> 0; mode=10 -> 28; same results with the big device as first and as last beat.
REQ-037 Cutoff and gaps: frame of REQ-036 with beat W=7,V_GS=0,V_DS=3 in place of one W=0 beat and 1-4 idle cycles between beats, mode=11 -> 252, single out_valid pulse.
REQ-038 Reset: 3 beats, rst_n low 2 cycles, then REQ-035 frame mode=01 -> out_n=144, no pulse for aborted frame; in_valid held high into DONE cycle -> that beat ignored, next frame counts from its first post-DONE beat.
REQ-039 Back-to-back frames with mode toggled between frames -> each result per its own first-beat mode.

Source files
------------

// File: rtl/ise_smc_pipe.sv
// Purpose: per-frame MOSFET I_D/G_M evaluation; N_DEV beats are sorted on insertion
//   and the three largest or three smallest values are summed (plain or 3/4/5 weighted).
// Latency: out_valid/out_n pulse one cycle after the edge that samples beat N_DEV.
// Backpressure: none; beats offered while the one-cycle DONE state is active are dropped.
// Ports: clk, rst_n (async, active-low); in_valid, mode[1:0], W, V_GS, V_DS in;
//   out_valid, out_n[OUT_W-1:0] out (out_n forced to zero when out_valid is low).
module ise_smc_pipe #(
  parameter int N_DEV = 6,
  parameter int IN_W  = 3,
  localparam int VAL_W = 3 * IN_W,
  localparam int OUT_W = VAL_W + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  W,
  input  logic [IN_W-1:0]  V_GS,
  input  logic [IN_W-1:0]  V_DS,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n
);

  // Two guard bits over VAL_W so that 2*W*V before the divide never wraps.
  localparam int PW = VAL_W + 2;
  localparam int CW = $clog2(N_DEV + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [VAL_W-1:0] buf_q [N_DEV];
  logic [VAL_W-1:0] buf_d [N_DEV];
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_n_q, out_n_d;

  // ---------------- per-beat device value ----------------
  logic             beat_sel_id;
  logic [PW-1:0]    w_x, vds_x, vov_x, id_num, gm_num;
  logic             triode;
  logic [VAL_W-1:0] beat_val;

  always_comb begin
    // The first beat of a frame uses the live mode; later beats use the latched one.
    beat_sel_id = (state_q == IDLE) ? mode[0] : mode_q[0];
    w_x   = PW'(W);
    vds_x = PW'(V_DS);
    // Cutoff maps to vov=0, which lands in the saturation branch with I_D=G_M=0.
    vov_x = (V_GS == '0) ? '0 : PW'(V_GS) - PW'(1);
    triode = (vov_x > vds_x);
    if (triode) begin
      id_num = w_x * ((PW'(2) * vov_x * vds_x) - (vds_x * vds_x));
      gm_num = PW'(2) * w_x * vds_x;
    end else begin
      id_num = w_x * vov_x * vov_x;
      gm_num = PW'(2) * w_x * vov_x;
    end
    beat_val = beat_sel_id ? VAL_W'(id_num / PW'(3)) : VAL_W'(gm_num / PW'(3));
  end

  // ---------------- descending sorted insert ----------------
  // Empty slots hold zero, which is already the correct sorted position for
  // missing entries, so no per-slot occupancy flags are needed.
  logic [N_DEV-1:0] gt;
  logic [VAL_W-1:0] ins_buf [N_DEV];

  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      gt[i] = (beat_val > buf_q[i]);
    end
    ins_buf[0] = gt[0] ? beat_val : buf_q[0];
    for (int i = 1; i < N_DEV; i++) begin
      if (!gt[i])       ins_buf[i] = buf_q[i];
      else if (gt[i-1]) ins_buf[i] = buf_q[i-1];
      else              ins_buf[i] = beat_val;
    end
  end

  // ---------------- frame result from the final sorted buffer ----------------
  logic [OUT_W-1:0] sa, sb, sc, frame_res;

  always_comb begin
    if (mode_q[1]) begin
      sa = OUT_W'(ins_buf[0]);
      sb = OUT_W'(ins_buf[1]);
      sc = OUT_W'(ins_buf[2]);
    end else begin
      sa = OUT_W'(ins_buf[N_DEV-3]);
      sb = OUT_W'(ins_buf[N_DEV-2]);
      sc = OUT_W'(ins_buf[N_DEV-1]);
    end
    if (mode_q[0]) frame_res = OUT_W'(3) * sa + OUT_W'(4) * sb + OUT_W'(5) * sc;
    else           frame_res = sa + sb + sc;
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    buf_d       = buf_q;
    out_valid_d = 1'b0;
    out_n_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = mode;
          buf_d   = ins_buf;
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          buf_d = ins_buf;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N_DEV - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_n_d     = frame_res;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        for (int i = 0; i < N_DEV; i++) buf_d[i] = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
      for (int i = 0; i < N_DEV; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      buf_q       <= buf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

endmodule
